// File: rtl/avalon_mm_simple_master_pkg.sv
// -----------------------------------------------------------------------------
// avalon_mm_simple_master_pkg
// Shared definitions for the simple Avalon-MM initiator:
//   - FSM state encoding (IDLE / BUS / RDWAIT / RESP)
//   - default bus widths and the default slave read latency, which matches
//     the register-slave pipeline used elsewhere in this design
//   - helper that picks the width of the optional waitrequest timeout counter
// -----------------------------------------------------------------------------
package avalon_mm_simple_master_pkg;

   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_ADDR_WIDTH     = 4;
   localparam int DEF_READ_LATENCY   = 2;
   localparam int DEF_TIMEOUT_CYCLES = 255;

   // FSM state encoding, kept as plain constants for legacy tool flows
   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_BUS    = 2'd1;
   localparam state_t ST_RDWAIT = 2'd2;
   localparam state_t ST_RESP   = 2'd3;

   // Timeout counter width: 8 bits covers the default limit, 16 bits anything
   // larger (limits above 65535 are not supported).
   function automatic int timeout_cnt_width(input int cycles);
      if (cycles > 255) begin
         return 16;
      end else begin
         return 8;
      end
   endfunction

endpackage

// File: rtl/avalon_mm_simple_master.sv
// -----------------------------------------------------------------------------
// avalon_mm_simple_master
// Avalon-MM initiator for the register-bank slaves. Takes one read or write
// command at a time from a valid/ready user port, runs exactly one bus
// transaction for it (honouring waitrequest and a fixed read latency) and
// returns a one-cycle response strobe.
//
// Optional feature (compile-time macro AVM_MASTER_TIMEOUT_EN):
//   when defined, a request stalled by waitrequest for TIMEOUT_CYCLES cycles
//   is abandoned and answered with rsp_error=1 (read data forced to 0).
//   When not defined, rsp_error is constant 0 and the bus waits indefinitely.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_write           1 = write, 0 = read
//   cmd_address         word address
//   cmd_writedata       write data
//   cmd_byteenable      byte lanes for writes
//   rsp_valid           one-cycle response strobe
//   rsp_is_read         response belongs to a read
//   rsp_readdata        last read result, held until the next read response
//   rsp_error           transaction aborted by timeout
//   master_*            Avalon-MM initiator interface, all outputs registered
//
// Parameters:
//   DATA_WIDTH      data width, multiple of 8
//   ADDR_WIDTH      word address width
//   READ_LATENCY    slave read latency in cycles, 0..7
//   TIMEOUT_CYCLES  stall limit (1..65535), only used with the timeout macro
// -----------------------------------------------------------------------------
module avalon_mm_simple_master
   import avalon_mm_simple_master_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int READ_LATENCY   = DEF_READ_LATENCY,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)(
   input  logic                      clk,
   input  logic                      reset,

   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_address,
   input  logic [DATA_WIDTH-1:0]     cmd_writedata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_byteenable,

   output logic                      rsp_valid,
   output logic                      rsp_is_read,
   output logic [DATA_WIDTH-1:0]     rsp_readdata,
   output logic                      rsp_error,

   output logic [ADDR_WIDTH-1:0]     master_address,
   output logic                      master_read,
   output logic                      master_write,
   output logic [DATA_WIDTH-1:0]     master_writedata,
   output logic [DATA_WIDTH/8-1:0]   master_byteenable,
   input  logic                      master_waitrequest,
   input  logic [DATA_WIDTH-1:0]     master_readdata
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;

   // ---------------------------------------------------------------- state
   state_t                  state_r;
   state_t                  state_nxt_s;

   // Latched command
   logic                    is_write_r;
   logic [ADDR_WIDTH-1:0]   address_r;
   logic [DATA_WIDTH-1:0]   writedata_r;
   logic [BE_WIDTH-1:0]     byteenable_r;
   logic                    master_read_r;
   logic                    master_write_r;

   // Read latency countdown, loaded when the read request is accepted
   logic [2:0]              lat_cnt_r;

   // Registered user-side outputs
   logic                    cmd_ready_r;
   logic                    rsp_valid_r;
   logic                    rsp_is_read_r;
   logic [DATA_WIDTH-1:0]   rsp_readdata_r;

   // Decoded events for the current cycle
   logic                    accept_s;
   logic                    bus_done_s;
   logic                    lat_done_s;
   logic                    timeout_s;
   logic                    capture_s;
   logic                    resp_enter_s;

   assign cmd_ready         = cmd_ready_r;
   assign rsp_valid         = rsp_valid_r;
   assign rsp_is_read       = rsp_is_read_r;
   assign rsp_readdata      = rsp_readdata_r;
   assign master_address    = address_r;
   assign master_read       = master_read_r;
   assign master_write      = master_write_r;
   assign master_writedata  = writedata_r;
   assign master_byteenable = byteenable_r;

   // ------------------------------------------------------ optional timeout
`ifdef AVM_MASTER_TIMEOUT_EN
   localparam int              TO_W    = timeout_cnt_width(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt_r;
   logic            rsp_error_r;

   // Abort when this stalled cycle is the TIMEOUT_CYCLES-th in a row
   always_comb begin
      timeout_s = 1'b0;
      if ((state_r == ST_BUS) && master_waitrequest && (to_cnt_r == TO_LAST)) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
   end

   // Stall counter: cleared whenever a new request enters BUS
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt_r <= '0;
      end else if (accept_s) begin
         to_cnt_r <= '0;
      end else if ((state_r == ST_BUS) && master_waitrequest) begin
         to_cnt_r <= to_cnt_r + TO_W'(1);
      end else begin
         to_cnt_r <= to_cnt_r;
      end
   end

   // Error flag travels with the response strobe
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_error_r <= 1'b0;
      end else begin
         rsp_error_r <= timeout_s;
      end
   end

   assign rsp_error = rsp_error_r;
`else
   logic unused_timeout_s;

   assign timeout_s        = 1'b0;
   assign rsp_error        = 1'b0;
   assign unused_timeout_s = (TIMEOUT_CYCLES != 32'sd0);
`endif

   // ------------------------------------------------------------- decoding
   // Per-cycle events derived from the current state and bus inputs
   always_comb begin
      accept_s     = (state_r == ST_IDLE) && cmd_valid;
      bus_done_s   = (state_r == ST_BUS) && !master_waitrequest;
      lat_done_s   = (state_r == ST_RDWAIT) && (lat_cnt_r <= 3'd1);
      // Zero-latency slaves present read data on the accepting edge itself
      capture_s    = !is_write_r &&
                     ((bus_done_s && (READ_LATENCY == 0)) || lat_done_s);
      resp_enter_s = (state_nxt_s == ST_RESP) && (state_r != ST_RESP);
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_nxt_s = ST_BUS;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BUS: begin
            if (timeout_s) begin
               state_nxt_s = ST_RESP;
            end else if (!master_waitrequest) begin
               if (is_write_r || (READ_LATENCY == 0)) begin
                  state_nxt_s = ST_RESP;
               end else begin
                  state_nxt_s = ST_RDWAIT;
               end
            end else begin
               state_nxt_s = ST_BUS;
            end
         end
         ST_RDWAIT: begin
            if (lat_cnt_r <= 3'd1) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_RDWAIT;
            end
         end
         ST_RESP: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------ registers
   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Command latch: address/data/lanes only change on acceptance in IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         is_write_r   <= 1'b0;
         address_r    <= '0;
         writedata_r  <= '0;
         byteenable_r <= '0;
      end else if (accept_s) begin
         is_write_r   <= cmd_write;
         address_r    <= cmd_address;
         writedata_r  <= cmd_writedata;
         byteenable_r <= cmd_byteenable;
      end else begin
         is_write_r   <= is_write_r;
         address_r    <= address_r;
         writedata_r  <= writedata_r;
         byteenable_r <= byteenable_r;
      end
   end

   // Bus request strobes: exactly one of them is raised per command
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         master_read_r  <= 1'b0;
         master_write_r <= 1'b0;
      end else if (accept_s) begin
         master_read_r  <= !cmd_write;
         master_write_r <= cmd_write;
      end else if (bus_done_s || timeout_s) begin
         master_read_r  <= 1'b0;
         master_write_r <= 1'b0;
      end else begin
         master_read_r  <= master_read_r;
         master_write_r <= master_write_r;
      end
   end

   // Read latency countdown
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_cnt_r <= 3'd0;
      end else if (bus_done_s) begin
         lat_cnt_r <= 3'(READ_LATENCY);
      end else if (state_r == ST_RDWAIT) begin
         lat_cnt_r <= lat_cnt_r - 3'd1;
      end else begin
         lat_cnt_r <= lat_cnt_r;
      end
   end

   // Command-side ready: high exactly while the FSM sits in IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_ready_r <= 1'b1;
      end else begin
         cmd_ready_r <= (state_nxt_s == ST_IDLE);
      end
   end

   // Response strobe and response type
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid_r   <= 1'b0;
         rsp_is_read_r <= 1'b0;
      end else if (resp_enter_s) begin
         rsp_valid_r   <= 1'b1;
         rsp_is_read_r <= !is_write_r;
      end else begin
         rsp_valid_r   <= 1'b0;
         rsp_is_read_r <= rsp_is_read_r;
      end
   end

   // Read data: updated only by read responses; an aborted read returns 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_readdata_r <= '0;
      end else if (capture_s) begin
         rsp_readdata_r <= master_readdata;
      end else if (timeout_s && !is_write_r) begin
         rsp_readdata_r <= '0;
      end else begin
         rsp_readdata_r <= rsp_readdata_r;
      end
   end

endmodule

// File: tb/tb_avalon_mm_simple_master.sv
// -----------------------------------------------------------------------------
// tb_avalon_mm_simple_master
// Self-checking bench for avalon_mm_simple_master (default parameters, with
// TIMEOUT_CYCLES=10 so the optional timeout can be exercised when the
// AVM_MASTER_TIMEOUT_EN macro is defined). A small register-slave model with
// programmable waitrequest stalls and a two-cycle read pipeline answers the
// bus. Directed vectors carry hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_avalon_mm_simple_master;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int BW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_address;
   logic [DW-1:0] cmd_writedata;
   logic [BW-1:0] cmd_byteenable;
   logic          rsp_valid;
   logic          rsp_is_read;
   logic [DW-1:0] rsp_readdata;
   logic          rsp_error;
   logic [AW-1:0] master_address;
   logic          master_read;
   logic          master_write;
   logic [DW-1:0] master_writedata;
   logic [BW-1:0] master_byteenable;
   logic          master_waitrequest;
   logic [DW-1:0] master_readdata;

   always #5 clk = ~clk;

   avalon_mm_simple_master #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .READ_LATENCY   (2),
      .TIMEOUT_CYCLES (10)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .cmd_valid          (cmd_valid),
      .cmd_ready          (cmd_ready),
      .cmd_write          (cmd_write),
      .cmd_address        (cmd_address),
      .cmd_writedata      (cmd_writedata),
      .cmd_byteenable     (cmd_byteenable),
      .rsp_valid          (rsp_valid),
      .rsp_is_read        (rsp_is_read),
      .rsp_readdata       (rsp_readdata),
      .rsp_error          (rsp_error),
      .master_address     (master_address),
      .master_read        (master_read),
      .master_write       (master_write),
      .master_writedata   (master_writedata),
      .master_byteenable  (master_byteenable),
      .master_waitrequest (master_waitrequest),
      .master_readdata    (master_readdata)
   );

   // ------------------------------------------------------------ slave model
   logic [DW-1:0] mem [16];
   logic [DW-1:0] rd_pipe0;
   logic [DW-1:0] rd_pipe1;
   int            stall_n    = 0;
   logic          wait_stuck = 1'b0;
   int            stall_seen;

   assign master_waitrequest = wait_stuck |
                               ((master_read | master_write) && (stall_seen < stall_n));
   assign master_readdata    = rd_pipe1;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
         rd_pipe0   <= '0;
         rd_pipe1   <= '0;
         stall_seen <= 0;
      end else begin
         rd_pipe1 <= rd_pipe0;
         rd_pipe0 <= '0;
         if (master_read | master_write) begin
            if (master_waitrequest) begin
               stall_seen <= stall_seen + 1;
            end else begin
               stall_seen <= 0;
               if (master_write) begin
                  for (int b = 0; b < BW; b++)
                     if (master_byteenable[b]) mem[master_address][8*b +: 8] <= master_writedata[8*b +: 8];
               end else begin
                  rd_pipe0 <= mem[master_address];
               end
            end
         end else begin
            stall_seen <= 0;
         end
      end
   end

   // ---------------------------------------------------------------- monitor
   int            cyc          = 0;
   int            req_cycles   = 0;
   int            overlap_cnt  = 0;
   int            unstable_cnt = 0;
   int            rsp_log_n    = 0;
   logic [DW-1:0] log_data [64];
   logic          log_is_read [64];
   logic          prev_req   = 1'b0;
   logic          prev_rd    = 1'b0;
   logic [AW-1:0] prev_addr  = '0;
   logic [DW-1:0] prev_wdata = '0;
   logic [BW-1:0] prev_be    = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (master_read && master_write) overlap_cnt <= overlap_cnt + 1;
      if (master_read || master_write) begin
         req_cycles <= req_cycles + 1;
         if (prev_req && ((master_address != prev_addr) || (master_writedata != prev_wdata) ||
                          (master_byteenable != prev_be) || (master_read != prev_rd)))
            unstable_cnt <= unstable_cnt + 1;
      end
      prev_req   <= master_read || master_write;
      prev_rd    <= master_read;
      prev_addr  <= master_address;
      prev_wdata <= master_writedata;
      prev_be    <= master_byteenable;
      if (rsp_valid && (rsp_log_n < 64)) begin
         log_data[rsp_log_n]    <= rsp_readdata;
         log_is_read[rsp_log_n] <= rsp_is_read;
         rsp_log_n              <= rsp_log_n + 1;
      end
   end

   // --------------------------------------------------------------- checking
   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [BW-1:0] be;
      int            stall;
      logic [DW-1:0] exp_rd;
      int            exp_lat;
   } vec_t;

   vec_t vecs [11];

   // One command: present it, check the bus request and the response timing.
   // Entered and left on a negative edge with the DUT idle.
   task automatic run_vec(input string tag, input vec_t v, input logic exp_err, input int exp_req);
      int   guard;
      int   lat;
      int   r0;
      logic leak;
      cmd_write      = v.wr;
      cmd_address    = v.addr;
      cmd_writedata  = v.data;
      cmd_byteenable = v.be;
      stall_n        = v.stall;
      cmd_valid      = 1'b1;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "_accept"}, 32'(guard < 50), 32'd1);
      r0 = req_cycles;
      @(negedge clk);
      cmd_valid = 1'b0;
      check({tag, "_mwrite"}, 32'(master_write), 32'(v.wr));
      check({tag, "_mread"}, 32'(master_read), 32'(!v.wr));
      check({tag, "_maddr"}, 32'(master_address), 32'(v.addr));
      check({tag, "_mwdata"}, master_writedata, v.data);
      check({tag, "_mbe"}, 32'(master_byteenable), 32'(v.be));
      lat  = 1;
      leak = 1'b0;
      while (!rsp_valid && lat < 100) begin
         if (cmd_ready) leak = 1'b1;
         @(negedge clk);
         lat++;
      end
      if (cmd_ready) leak = 1'b1;
      check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
      check({tag, "_ready_low"}, 32'(leak), 32'd0);
      check({tag, "_is_read"}, 32'(rsp_is_read), 32'(!v.wr));
      check({tag, "_rdata"}, rsp_readdata, v.exp_rd);
      check({tag, "_error"}, 32'(rsp_error), 32'(exp_err));
      check({tag, "_req_cycles"}, 32'(req_cycles - r0), 32'(exp_req));
      @(negedge clk);
      check({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
   endtask

   vec_t bb [4];
   vec_t tv;

   initial begin
      int n0;
      int guard;
      int acc_cyc [4];

      //             wr    addr   data           be    stall exp_rd         exp_lat
      vecs[0]  = '{1'b1, 4'd0,  32'h12345678, 4'hF, 0, 32'h00000000, 2};
      vecs[1]  = '{1'b0, 4'd0,  32'h00000000, 4'hF, 0, 32'h12345678, 4};
      vecs[2]  = '{1'b1, 4'd3,  32'hDEADBEEF, 4'hF, 5, 32'h12345678, 7};
      vecs[3]  = '{1'b0, 4'd3,  32'h00000000, 4'hF, 2, 32'hDEADBEEF, 6};
      vecs[4]  = '{1'b1, 4'd5,  32'hAABBCCDD, 4'h5, 0, 32'hDEADBEEF, 2};
      vecs[5]  = '{1'b0, 4'd5,  32'h00000000, 4'hF, 0, 32'h00BB00DD, 4};
      vecs[6]  = '{1'b1, 4'd15, 32'hFFFFFFFF, 4'h8, 1, 32'h00BB00DD, 3};
      vecs[7]  = '{1'b0, 4'd15, 32'h00000000, 4'hF, 0, 32'hFF000000, 4};
      vecs[8]  = '{1'b1, 4'd15, 32'h11111111, 4'h0, 0, 32'hFF000000, 2};
      vecs[9]  = '{1'b0, 4'd15, 32'h00000000, 4'hF, 3, 32'hFF000000, 7};
      vecs[10] = '{1'b0, 4'd7,  32'h00000000, 4'hF, 0, 32'h00000000, 4};

      bb[0] = '{1'b1, 4'd2, 32'h01020304, 4'hF, 0, 32'h0, 0};
      bb[1] = '{1'b0, 4'd2, 32'h00000000, 4'hF, 0, 32'h0, 0};
      bb[2] = '{1'b1, 4'd2, 32'hA5A55A5A, 4'hF, 0, 32'h0, 0};
      bb[3] = '{1'b0, 4'd2, 32'h00000000, 4'hF, 0, 32'h0, 0};

      // Reset state
      reset          = 1'b1;
      cmd_valid      = 1'b0;
      cmd_write      = 1'b0;
      cmd_address    = '0;
      cmd_writedata  = '0;
      cmd_byteenable = '0;
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_is_read", 32'(rsp_is_read), 32'd0);
      check("rst_rsp_readdata", rsp_readdata, 32'd0);
      check("rst_rsp_error", 32'(rsp_error), 32'd0);
      check("rst_master_rw", 32'({master_read, master_write}), 32'd0);
      check("rst_master_addr", 32'(master_address), 32'd0);
      check("rst_master_wdata", master_writedata, 32'd0);
      check("rst_master_be", 32'(master_byteenable), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Directed single commands
      for (int i = 0; i < 11; i++)
         run_vec($sformatf("v%0d", i), vecs[i], 1'b0, 1 + vecs[i].stall);

      // Back-to-back: cmd_valid held high across four alternating commands
      n0 = rsp_log_n;
      stall_n        = 0;
      cmd_write      = bb[0].wr;
      cmd_address    = bb[0].addr;
      cmd_writedata  = bb[0].data;
      cmd_byteenable = bb[0].be;
      cmd_valid      = 1'b1;
      for (int k = 0; k < 4; k++) begin
         guard = 0;
         while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         check($sformatf("b2b_accept%0d", k), 32'(guard < 50), 32'd1);
         acc_cyc[k] = cyc;
         @(negedge clk);
         if (k < 3) begin
            cmd_write      = bb[k+1].wr;
            cmd_address    = bb[k+1].addr;
            cmd_writedata  = bb[k+1].data;
            cmd_byteenable = bb[k+1].be;
         end else begin
            cmd_valid = 1'b0;
         end
      end
      guard = 0;
      while ((rsp_log_n < n0 + 4) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("b2b_rsp_count", 32'(rsp_log_n - n0), 32'd4);
      check("b2b_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      check("b2b_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'd5);
      check("b2b_gap2", 32'(acc_cyc[3] - acc_cyc[2]), 32'd3);
      check("b2b_is_read0", 32'(log_is_read[n0]), 32'd0);
      check("b2b_is_read1", 32'(log_is_read[n0+1]), 32'd1);
      check("b2b_is_read2", 32'(log_is_read[n0+2]), 32'd0);
      check("b2b_is_read3", 32'(log_is_read[n0+3]), 32'd1);
      check("b2b_rdata1", log_data[n0+1], 32'h01020304);
      check("b2b_rdata3", log_data[n0+3], 32'hA5A55A5A);
      @(negedge clk);

`ifdef AVM_MASTER_TIMEOUT_EN
      // Timeout: waitrequest stuck high, abort after 10 stalled cycles
      wait_stuck = 1'b1;
      tv = '{1'b1, 4'd1, 32'h00000077, 4'hF, 0, 32'hA5A55A5A, 11};
      run_vec("to_write", tv, 1'b1, 10);
      tv = '{1'b0, 4'd1, 32'h00000000, 4'hF, 0, 32'h00000000, 11};
      run_vec("to_read", tv, 1'b1, 10);
      wait_stuck = 1'b0;
`endif

      // Reset in the middle of a stalled write
      n0 = rsp_log_n;
      stall_n        = 20;
      cmd_write      = 1'b1;
      cmd_address    = 4'd4;
      cmd_writedata  = 32'h0BADF00D;
      cmd_byteenable = 4'hF;
      cmd_valid      = 1'b1;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_rst_write_before", 32'(master_write), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_write_drop", 32'(master_write), 32'd0);
      @(negedge clk);
      reset   = 1'b0;
      stall_n = 0;
      repeat (3) @(negedge clk);
      check("mid_rst_no_rsp", 32'(rsp_log_n - n0), 32'd0);
      check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);

      // Recovery after reset
      tv = '{1'b1, 4'd4, 32'h00005A5A, 4'hF, 0, 32'h00000000, 2};
      run_vec("post_rst_w", tv, 1'b0, 1);
      tv = '{1'b0, 4'd4, 32'h00000000, 4'hF, 0, 32'h00005A5A, 4};
      run_vec("post_rst_r", tv, 1'b0, 1);

      check("no_rw_overlap", 32'(overlap_cnt), 32'd0);
      check("req_stable", 32'(unstable_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

endmodule
